// File: rtl/fp_job_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fp_job_sched
//  Purpose  : Round-robin job scheduler for the int2flt / flt2int / fltadd
//             conversion engines. Accepts one job at a time, pulses the
//             selected engine's req, waits for its done under a watchdog and
//             emits a one-cycle completion record.
//  Revision : 1.0  initial release
// ============================================================================
module fp_job_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,        // asynchronous, active-low
    input  logic [NREQ-1:0]   job_valid,
    input  logic [2*NREQ-1:0] job_op,
    output logic [NREQ-1:0]   job_ready,
    output logic [2:0]        unit_req,
    input  logic [2:0]        unit_done,
    output logic              busy,
    output logic              cmpl_valid,
    output logic [IDW-1:0]    cmpl_id,
    output logic [1:0]        cmpl_status,
    output logic [7:0]        job_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [1:0] C_ST_OK   = 2'b00;
    localparam logic [1:0] C_ST_TMO  = 2'b01;
    localparam logic [1:0] C_ST_ILL  = 2'b10;
    localparam logic [1:0] C_OP_ILL  = 2'd3;
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);
    localparam int         SW         = IDW + 1;

    logic [2:0]      r_state;
    logic [IDW-1:0]  r_rr;
    logic [IDW-1:0]  r_id;
    logic [1:0]      r_op;
    logic [1:0]      r_status;
    logic [7:0]      r_timer;
    logic [7:0]      r_count;

    logic            w_any;
    logic [IDW-1:0]  w_grant_id;
    logic [NREQ-1:0] w_grant;
    logic [SW-1:0]   w_sum;
    logic [IDW-1:0]  w_idx;
    logic [1:0]      w_grant_op;

    // Round-robin search: scan downward in offset so the lowest offset from r_rr wins
    always_comb begin
        w_grant_id = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (job_valid[w_idx]) begin
                w_grant_id = w_idx;
            end
        end
    end

    assign w_any      = |job_valid;
    assign w_grant    = w_any ? (NREQ'(1) << w_grant_id) : '0;
    assign w_grant_op = job_op[{w_grant_id, 1'b0} +: 2];

    // Control FSM, round-robin pointer, watchdog timer and completion counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_rr     <= '0;
            r_id     <= '0;
            r_op     <= '0;
            r_status <= C_ST_OK;
            r_timer  <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_grant_id;
                        r_op    <= w_grant_op;
                        r_rr    <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_op == C_OP_ILL) begin
                        r_status <= C_ST_ILL;
                        r_state  <= S_REPORT;
                    end else begin
                        r_state  <= S_ARM;
                    end
                end
                S_ARM: begin
                    // Engine done may still be stale from its previous job here
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (unit_done[r_op]) begin
                        r_status <= C_ST_OK;
                        r_state  <= S_REPORT;
                    end else if (r_timer == C_TMO_LAST) begin
                        r_status <= C_ST_TMO;
                        r_state  <= S_REPORT;
                    end else begin
                        r_timer  <= r_timer + 8'd1;
                    end
                end
                S_REPORT: begin
                    r_count <= r_count + 8'd1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // job_ready is gated by reset so it is low while reset is held even with valid requests
    assign job_ready   = (reset && (r_state == S_IDLE)) ? w_grant : '0;
    assign unit_req    = ((r_state == S_ISSUE) && (r_op != C_OP_ILL)) ? (3'b001 << r_op) : 3'b000;
    assign busy        = (r_state != S_IDLE);
    assign cmpl_valid  = (r_state == S_REPORT);
    assign cmpl_id     = cmpl_valid ? r_id : '0;
    assign cmpl_status = cmpl_valid ? r_status : 2'b00;
    assign job_count   = r_count;

endmodule
`default_nettype wire
